bin_to_bcd_7seg: RTL and testbench

BIN_TO_BCD_7SEG -- requirements
Module: bin_to_bcd_7seg

---
 rtl/bin_to_bcd_7seg.sv | 99 +++++++++
 tb/tb_bin_to_bcd_7seg.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_7seg.sv
// Binary (unsigned or two's complement) to packed BCD with a registered
// 7-segment display driver: three magnitude digits plus a sign digit.
module bin_to_bcd_7seg #(
  parameter int NB_DATA = 8,
  parameter int NB_BCD  = 12
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_bin,
  input  logic               i_sign,
  output logic [NB_BCD-1:0]  o_bcd,
  output logic               o_negative,
  output logic [6:0]         o_seg0,
  output logic [6:0]         o_seg1,
  output logic [6:0]         o_seg2,
  output logic [6:0]         o_seg3
);

  localparam int         NB_DIG    = NB_BCD / 4;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit, input logic en);
    logic [6:0] seg;
    // NOTE: the default arm gives every path a value, so no latch is inferred.
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return en ? seg : SEG_BLANK;
  endfunction

  logic [NB_DATA-1:0] magnitude;
  logic [NB_BCD-1:0]  bcd;
  logic [NB_BCD-1:0]  bcd_d, bcd_q;
  logic               negative_d, negative_q;
  logic [6:0]         seg0_d, seg0_q;
  logic [6:0]         seg1_d, seg1_q;
  logic [6:0]         seg2_d, seg2_q;
  logic [6:0]         seg3_d, seg3_q;

  always_comb begin
    // NOTE: blocking assignments here; bcd is rebuilt step by step within one evaluation.
    negative_d = i_sign & i_bin[NB_DATA-1];
    magnitude  = negative_d ? -i_bin : i_bin;

    bcd = '0;
    for (int i = NB_DATA - 1; i >= 0; i--) begin
      for (int d = 0; d < NB_DIG; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[NB_BCD-2:0], magnitude[i]};
    end
    bcd_d = bcd;

    // Blanking enables come from this cycle's BCD so all outputs stay consistent.
    seg0_d = seg_decode(bcd_d[3:0], 1'b1);
    seg1_d = seg_decode(bcd_d[7:4], |bcd_d[NB_BCD-1:4]);
    seg2_d = seg_decode(bcd_d[11:8], |bcd_d[NB_BCD-1:8]);
    seg3_d = negative_d ? SEG_MINUS : SEG_BLANK;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      bcd_q      <= '0;
      negative_q <= 1'b0;
      seg0_q     <= SEG_BLANK;
      seg1_q     <= SEG_BLANK;
      seg2_q     <= SEG_BLANK;
      seg3_q     <= SEG_BLANK;
    end else begin
      bcd_q      <= bcd_d;
      negative_q <= negative_d;
      seg0_q     <= seg0_d;
      seg1_q     <= seg1_d;
      seg2_q     <= seg2_d;
      seg3_q     <= seg3_d;
    end
  end

  assign o_bcd      = bcd_q;
  assign o_negative = negative_q;
  assign o_seg0     = seg0_q;
  assign o_seg1     = seg1_q;
  assign o_seg2     = seg2_q;
  assign o_seg3     = seg3_q;

endmodule

// File: tb/tb_bin_to_bcd_7seg.sv
// Directed-vector bench for bin_to_bcd_7seg: reset, conversion table,
// one-cycle latency and mid-stream asynchronous reset.
module tb_bin_to_bcd_7seg;

  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [6:0] MIN = 7'b0111111;
  localparam logic [6:0] D0  = 7'b1000000;
  localparam logic [6:0] D1  = 7'b1111001;
  localparam logic [6:0] D2  = 7'b0100100;
  localparam logic [6:0] D5  = 7'b0010010;
  localparam logic [6:0] D7  = 7'b1111000;
  localparam logic [6:0] D8  = 7'b0000000;
  localparam logic [6:0] D9  = 7'b0010000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        neg;
    logic [6:0]  s0, s1, s2, s3;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bin;
  logic        sign;
  logic [11:0] o_bcd;
  logic        o_negative;
  logic [6:0]  o_seg0, o_seg1, o_seg2, o_seg3;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_7seg #(.NB_DATA(8), .NB_BCD(12)) dut (
    .i_clk(clk), .i_rst(rst), .i_bin(bin), .i_sign(sign),
    .o_bcd(o_bcd), .o_negative(o_negative),
    .o_seg0(o_seg0), .o_seg1(o_seg1), .o_seg2(o_seg2), .o_seg3(o_seg3)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; sign = 1'b0; bin = 8'd255;
    #1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({o_bcd, o_negative} !== 13'h0) begin
      bad++; $display("FAIL reset_bcd got=%h/%b exp=000/0", o_bcd, o_negative);
    end
    total++;
    if ({o_seg0, o_seg1, o_seg2, o_seg3} !== {4{BLK}}) begin
      bad++; $display("FAIL reset_seg got=%b %b %b %b exp=all 1111111", o_seg0, o_seg1, o_seg2, o_seg3);
    end
    // First edge after release loads the current input (255 unsigned).
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (o_bcd !== 12'h255 || o_seg2 !== D2) begin
      bad++; $display("FAIL reset_release got=%h seg2=%b exp=255 seg2=%b", o_bcd, o_seg2, D2);
    end
  endtask

  task automatic test_vectors();
    vec_t v[11];
    v[0]  = '{1'b1, 8'h00, 12'h000, 1'b0, D0, BLK, BLK, BLK};
    v[1]  = '{1'b1, 8'h07, 12'h007, 1'b0, D7, BLK, BLK, BLK};
    v[2]  = '{1'b1, 8'h63, 12'h099, 1'b0, D9, D9, BLK, BLK};
    v[3]  = '{1'b1, 8'hCE, 12'h050, 1'b1, D0, D5, BLK, MIN};
    v[4]  = '{1'b0, 8'hFF, 12'h255, 1'b0, D5, D5, D2, BLK};
    v[5]  = '{1'b1, 8'hFF, 12'h001, 1'b1, D1, BLK, BLK, MIN};
    v[6]  = '{1'b1, 8'h80, 12'h128, 1'b1, D8, D2, D1, MIN};
    v[7]  = '{1'b0, 8'h80, 12'h128, 1'b0, D8, D2, D1, BLK};
    v[8]  = '{1'b0, 8'h64, 12'h100, 1'b0, D0, D0, D1, BLK};
    v[9]  = '{1'b0, 8'h0A, 12'h010, 1'b0, D0, D1, BLK, BLK};
    v[10] = '{1'b1, 8'h7F, 12'h127, 1'b0, D7, D2, D1, BLK};
    // Applied back to back: one new vector every cycle.
    for (int k = 0; k < 11; k++) begin
      @(negedge clk); sign = v[k].sign; bin = v[k].bin;
      @(posedge clk); #1;
      total++;
      if (o_bcd !== v[k].bcd) begin
        bad++; $display("FAIL vec%0d_bcd got=%h exp=%h", k, o_bcd, v[k].bcd);
      end
      total++;
      if (o_negative !== v[k].neg) begin
        bad++; $display("FAIL vec%0d_neg got=%b exp=%b", k, o_negative, v[k].neg);
      end
      total++;
      if ({o_seg3, o_seg2, o_seg1, o_seg0} !== {v[k].s3, v[k].s2, v[k].s1, v[k].s0}) begin
        bad++; $display("FAIL vec%0d_seg got=%b_%b_%b_%b exp=%b_%b_%b_%b", k,
                        o_seg3, o_seg2, o_seg1, o_seg0, v[k].s3, v[k].s2, v[k].s1, v[k].s0);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk); sign = 1'b0; bin = 8'd7;
    @(posedge clk); #1;
    @(negedge clk); sign = 1'b1; bin = 8'hCE;
    #2;
    total++;
    if (o_bcd !== 12'h007 || o_negative !== 1'b0) begin
      bad++; $display("FAIL latency_hold got=%h/%b exp=007/0", o_bcd, o_negative);
    end
    @(posedge clk); #1;
    total++;
    if (o_bcd !== 12'h050 || o_negative !== 1'b1 || o_seg3 !== MIN) begin
      bad++; $display("FAIL latency_update got=%h/%b/%b exp=050/1/%b", o_bcd, o_negative, o_seg3, MIN);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk); sign = 1'b1; bin = 8'h80;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total++;
    if ({o_bcd, o_negative} !== 13'h0) begin
      bad++; $display("FAIL midreset_bcd got=%h/%b exp=000/0", o_bcd, o_negative);
    end
    total++;
    if ({o_seg0, o_seg1, o_seg2, o_seg3} !== {4{BLK}}) begin
      bad++; $display("FAIL midreset_seg got=%b %b %b %b exp=all 1111111", o_seg0, o_seg1, o_seg2, o_seg3);
    end
    @(negedge clk); rst = 1'b0; sign = 1'b0; bin = 8'd99;
    @(posedge clk); #1;
    total++;
    if (o_bcd !== 12'h099 || o_seg1 !== D9 || o_seg2 !== BLK) begin
      bad++; $display("FAIL midreset_recover got=%h/%b/%b exp=099/%b/%b", o_bcd, o_seg1, o_seg2, D9, BLK);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_latency();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
